// File: rtl/id_ex_pipe_if.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_if
// Bundles the signals between the decode stage and the ID/EX pipeline
// register. The ID_* fields come from decode and the EX_* fields go to
// execute and the forwarding unit. Stall_o returns the load-use stall
// request to the PC and IF/ID write enables.
//
// Modports:
//   slave  - the ID/EX register: takes ID_*, drives EX_* and Stall_o
//   master - the decode/control side: drives ID_*, observes EX_* and Stall_o
// ----------------------------------------------------------------------------
interface id_ex_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    // Decode-stage fields
    logic              ID_Valid;
    logic [REG_AW-1:0] ID_Rs1;
    logic [REG_AW-1:0] ID_Rs2;
    logic [REG_AW-1:0] ID_Rd;
    logic              ID_UseRs2;
    logic              ID_RegWrite;
    logic              ID_MemRead;
    logic              ID_MemWrite;
    logic              ID_MemtoReg;
    logic              ID_ALUSrc;
    logic [1:0]        ID_ALUOp;
    logic [9:0]        ID_Funct;
    logic [DATA_W-1:0] ID_RS1data;
    logic [DATA_W-1:0] ID_RS2data;
    logic [DATA_W-1:0] ID_Imm;

    // Execute-stage fields (registered)
    logic              EX_Valid;
    logic              EX_RegWrite;
    logic              EX_MemRead;
    logic              EX_MemWrite;
    logic              EX_MemtoReg;
    logic              EX_ALUSrc;
    logic [1:0]        EX_ALUOp;
    logic [9:0]        EX_Funct;
    logic [REG_AW-1:0] EX_Rs1;
    logic [REG_AW-1:0] EX_Rs2;
    logic [REG_AW-1:0] EX_Rd;
    logic [DATA_W-1:0] EX_RS1data;
    logic [DATA_W-1:0] EX_RS2data;
    logic [DATA_W-1:0] EX_Imm;

    // Load-use stall back to the front end
    logic              Stall_o;

    modport slave (
        input  ID_Valid, ID_Rs1, ID_Rs2, ID_Rd, ID_UseRs2,
               ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
               ID_ALUOp, ID_Funct, ID_RS1data, ID_RS2data, ID_Imm,
        output EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg,
               EX_ALUSrc, EX_ALUOp, EX_Funct, EX_Rs1, EX_Rs2, EX_Rd,
               EX_RS1data, EX_RS2data, EX_Imm, Stall_o
    );

    modport master (
        output ID_Valid, ID_Rs1, ID_Rs2, ID_Rd, ID_UseRs2,
               ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
               ID_ALUOp, ID_Funct, ID_RS1data, ID_RS2data, ID_Imm,
        input  EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg,
               EX_ALUSrc, EX_ALUOp, EX_Funct, EX_Rs1, EX_Rs2, EX_Rd,
               EX_RS1data, EX_RS2data, EX_Imm, Stall_o
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ----------------------------------------------------------------------------
// id_ex_pipe
// ID/EX pipeline register with load-use hazard detection for the 5-stage
// RISC-V core. It captures the decoded instruction into EX. When the
// instruction in EX is a load whose destination is read by the instruction
// in ID, it raises Stall_o and inserts a bubble into EX.
//
// Ports:
//   clk_i        - clock; all state updates on the rising edge
//   rst_i        - synchronous active-high reset (EX becomes a bubble)
//   mem_stall_i  - data-memory stall; freezes all state
//   flush_i      - kills the ID instruction; a bubble enters EX
//   bus          - id_ex_pipe_if.slave: ID_* in, EX_* and Stall_o out
//   bubble_cnt_o - (IDEX_PERF_CNT_EN only) count of hazard/flush bubbles
//   hold_cnt_o   - (IDEX_PERF_CNT_EN only) count of mem_stall_i cycles
//
// Optional feature macro: IDEX_PERF_CNT_EN
// ----------------------------------------------------------------------------
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_stall_i,
    input  logic        flush_i,
    id_ex_pipe_if.slave bus
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt_o,
    output logic [31:0] hold_cnt_o
`endif
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              memto_reg;
        logic              alu_src;
        logic [1:0]        alu_op;
        logic [9:0]        funct;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
    } ex_regs_t;

    ex_regs_t ex_q;
    ex_regs_t id_fields;
    logic     hazard;

    // Gather the ID-stage fields into one word so capture is a single assign.
    always_comb begin
        id_fields.valid     = bus.ID_Valid;
        id_fields.reg_write = bus.ID_RegWrite;
        id_fields.mem_read  = bus.ID_MemRead;
        id_fields.mem_write = bus.ID_MemWrite;
        id_fields.memto_reg = bus.ID_MemtoReg;
        id_fields.alu_src   = bus.ID_ALUSrc;
        id_fields.alu_op    = bus.ID_ALUOp;
        id_fields.funct     = bus.ID_Funct;
        id_fields.rs1       = bus.ID_Rs1;
        id_fields.rs2       = bus.ID_Rs2;
        id_fields.rd        = bus.ID_Rd;
        id_fields.rs1_data  = bus.ID_RS1data;
        id_fields.rs2_data  = bus.ID_RS2data;
        id_fields.imm       = bus.ID_Imm;
    end

    // A load in EX cannot forward its result to the very next instruction,
    // so any use of its Rd in ID must wait one cycle. x0 is never a real
    // dependency, and rs2 only counts when the instruction actually reads it.
    always_comb begin
        hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && bus.ID_Valid &&
                 ((ex_q.rd == bus.ID_Rs1) ||
                  (bus.ID_UseRs2 && (ex_q.rd == bus.ID_Rs2)));
    end

    // A flush already discards the ID instruction, so stalling for it would
    // only waste a cycle.
    assign bus.Stall_o = hazard && !flush_i;

    // Next-state priority: reset, memory hold, flush/hazard bubble, capture.
    // An invalid ID slot is captured as a full bubble so no stale indices
    // reach the forwarding unit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q <= '0;
        end else if (mem_stall_i) begin
            ex_q <= ex_q;
        end else if (flush_i || hazard || !bus.ID_Valid) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_fields;
        end
    end

    assign bus.EX_Valid    = ex_q.valid;
    assign bus.EX_RegWrite = ex_q.reg_write;
    assign bus.EX_MemRead  = ex_q.mem_read;
    assign bus.EX_MemWrite = ex_q.mem_write;
    assign bus.EX_MemtoReg = ex_q.memto_reg;
    assign bus.EX_ALUSrc   = ex_q.alu_src;
    assign bus.EX_ALUOp    = ex_q.alu_op;
    assign bus.EX_Funct    = ex_q.funct;
    assign bus.EX_Rs1      = ex_q.rs1;
    assign bus.EX_Rs2      = ex_q.rs2;
    assign bus.EX_Rd       = ex_q.rd;
    assign bus.EX_RS1data  = ex_q.rs1_data;
    assign bus.EX_RS2data  = ex_q.rs2_data;
    assign bus.EX_Imm      = ex_q.imm;

`ifdef IDEX_PERF_CNT_EN
    // Bubbles are counted only when a flush or hazard actually loads one;
    // a held cycle never loads anything, so it only bumps the hold count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_cnt_o <= '0;
            hold_cnt_o   <= '0;
        end else if (mem_stall_i) begin
            hold_cnt_o <= hold_cnt_o + 32'd1;
        end else if (flush_i || hazard) begin
            bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end
    end
`endif

endmodule
